// File: rtl/urv_writeback_if.sv
// -----------------------------------------------------------------------------
// urv_writeback_if
// Bundles the X/W pipeline inputs, data-memory completion, stall handshake and
// register-file write port of the uRV writeback stage.
//   slave  : the writeback stage (consumes x_*/dm_*/w_stall_i, drives rf_*/stall)
//   master : the surrounding pipeline / memory side
// -----------------------------------------------------------------------------
interface urv_writeback_if;
    // Stall handshake
    logic        w_stall_i;
    logic        w_stall_req_o;
    // X/W pipeline register outputs
    logic        x_valid_i;
    logic [2:0]  x_fun_i;
    logic        x_load_i;
    logic        x_store_i;
    logic [4:0]  x_rd_i;
    logic        x_rd_write_i;
    logic [1:0]  x_rd_source_i;
    logic [31:0] x_rd_value_i;
    logic [31:0] x_shifter_value_i;
    logic [31:0] x_multiply_value_i;
    logic [31:0] x_dm_addr_i;
    // Data memory completion
    logic [31:0] dm_data_l_i;
    logic        dm_load_done_i;
    logic        dm_store_done_i;
    // Register-file write port
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        rf_rd_write_o;

    modport slave (
        input  w_stall_i,
        output w_stall_req_o,
        input  x_valid_i, x_fun_i, x_load_i, x_store_i, x_rd_i, x_rd_write_i,
        input  x_rd_source_i, x_rd_value_i, x_shifter_value_i, x_multiply_value_i,
        input  x_dm_addr_i,
        input  dm_data_l_i, dm_load_done_i, dm_store_done_i,
        output rf_rd_o, rf_rd_value_o, rf_rd_write_o
    );

    modport master (
        output w_stall_i,
        input  w_stall_req_o,
        output x_valid_i, x_fun_i, x_load_i, x_store_i, x_rd_i, x_rd_write_i,
        output x_rd_source_i, x_rd_value_i, x_shifter_value_i, x_multiply_value_i,
        output x_dm_addr_i,
        output dm_data_l_i, dm_load_done_i, dm_store_done_i,
        input  rf_rd_o, rf_rd_value_o, rf_rd_write_o
    );
endinterface

// File: rtl/urv_writeback.sv
// -----------------------------------------------------------------------------
// urv_writeback
// Writeback stage of the uRV pipeline. Waits for data-memory completion of
// loads/stores (requesting a stall meanwhile), extracts and extends load data,
// selects the destination value and drives a registered register-file write.
// Ports:
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset
//   wb      : urv_writeback_if.slave (pipeline inputs, stall handshake, rf port)
// -----------------------------------------------------------------------------
module urv_writeback (
    input  logic            clk_i,
    input  logic            rst_n_i,
    urv_writeback_if.slave  wb
);

    typedef enum logic [1:0] {StIdle, StWait, StHeld} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_ld_buf;
    logic [4:0]  r_rf_rd;
    logic [31:0] r_rf_rd_value;
    logic        r_rf_rd_write;

    logic        w_mem_op;
    logic        w_done_now;
    logic        w_held;
    logic        w_done_eff;
    logic        w_stall_req;
    logic        w_complete;
    logic        w_ld_capture;
    logic [31:0] w_ld_word;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_value;
    logic [31:0] w_rd_value;
    logic        w_unused_addr;

    assign w_mem_op    = wb.x_valid_i & (wb.x_load_i | wb.x_store_i);
    assign w_done_now  = (wb.x_load_i & wb.dm_load_done_i) | (wb.x_store_i & wb.dm_store_done_i);
    assign w_held      = (r_state == StHeld);
    // Once HELD, completion is already recorded even though the pulse is gone.
    assign w_done_eff  = w_done_now | w_held;
    assign w_stall_req = w_mem_op & ~w_done_eff;
    assign w_complete  = wb.x_valid_i & ~wb.w_stall_i & ~w_stall_req;

    assign wb.w_stall_req_o = w_stall_req;

    // Only the low address bits select bytes/halves.
    assign w_unused_addr = ^wb.x_dm_addr_i[31:2];

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_mem_op) begin
                    if (!w_done_now) begin
                        w_state_next = StWait;
                    end else if (wb.w_stall_i) begin
                        w_state_next = StHeld;
                    end
                end
            end
            StWait: begin
                if (w_mem_op && w_done_now) begin
                    w_state_next = wb.w_stall_i ? StHeld : StIdle;
                end
            end
            StHeld: begin
                if (w_complete) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Load data must be captured on the completion pulse if the pipeline is
    // frozen, since dm_data_l_i is only valid during that pulse.
    assign w_ld_capture = wb.x_load_i & (w_state_next == StHeld) & ~w_held;

    assign w_ld_word = w_held ? r_ld_buf : wb.dm_data_l_i;

    always_comb begin
        w_ld_byte = w_ld_word[7:0];
        case (wb.x_dm_addr_i[1:0])
            2'd0:    w_ld_byte = w_ld_word[7:0];
            2'd1:    w_ld_byte = w_ld_word[15:8];
            2'd2:    w_ld_byte = w_ld_word[23:16];
            default: w_ld_byte = w_ld_word[31:24];
        endcase
    end

    assign w_ld_half = wb.x_dm_addr_i[1] ? w_ld_word[31:16] : w_ld_word[15:0];

    always_comb begin
        w_ld_value = w_ld_word;
        case (wb.x_fun_i)
            3'b000:  w_ld_value = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld_value = {{16{w_ld_half[15]}}, w_ld_half};
            3'b100:  w_ld_value = {24'd0, w_ld_byte};
            3'b101:  w_ld_value = {16'd0, w_ld_half};
            default: w_ld_value = w_ld_word;
        endcase
    end

    always_comb begin
        w_rd_value = wb.x_rd_value_i;
        if (wb.x_load_i) begin
            w_rd_value = w_ld_value;
        end else begin
            case (wb.x_rd_source_i)
                2'd1:    w_rd_value = wb.x_shifter_value_i;
                2'd2:    w_rd_value = wb.x_multiply_value_i;
                default: w_rd_value = wb.x_rd_value_i;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= StIdle;
            r_ld_buf <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_ld_capture) begin
                r_ld_buf <= wb.dm_data_l_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rf_rd       <= 5'd0;
            r_rf_rd_value <= 32'd0;
            r_rf_rd_write <= 1'b0;
        end else begin
            r_rf_rd_write <= 1'b0;
            if (w_complete) begin
                r_rf_rd       <= wb.x_rd_i;
                r_rf_rd_value <= w_rd_value;
                r_rf_rd_write <= wb.x_rd_write_i & ~wb.x_store_i & (wb.x_rd_i != 5'd0);
            end
        end
    end

    assign wb.rf_rd_o       = r_rf_rd;
    assign wb.rf_rd_value_o = r_rf_rd_value;
    assign wb.rf_rd_write_o = r_rf_rd_write;

endmodule
